dram_burst_model: RTL and testbench
===================================

Name: dram_burst_model

Overview:
- Parametrised successor to the single-port DRAM behavioural model used by the conv layer benches.
- Adds multi-requester round-robin read arbitration, burst reads with address wrap, and a configurable fixed read latency.
- Keeps an always-accepted write port.
- Sits between the layer engines (conv, pool, fc) and backing storage in block-level and system benches; the RTL is synthesizable.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 12, word address width; DEPTH = 1 << ADDR_WIDTH.
- N_RD, 2, number of read requesters (2..8).
- ID_WIDTH, 1, width of rd_id; must satisfy 2**ID_WIDTH >= N_RD.
- BURST_WIDTH, 4, width of each burst length field; burst = rd_len+1 beats (1..16).
- RD_LAT, 3, cycles from beat issue to rd_valid (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- srst  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_req  in  N_RD  per-requester read request; held high until granted.
- rd_addr  in  N_RD*ADDR_WIDTH  per-requester start address; slice i belongs to requester i.
- rd_len  in  N_RD*BURST_WIDTH  per-requester beats-minus-one.
- rd_gnt  out  N_RD  one-hot grant pulse, one cycle.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_WIDTH  read data.
- rd_id  out  ID_WIDTH  requester index of the current beat.
- rd_last  out  1  final beat of a burst.
- busy  out  1  FSM is in BURST or the latency pipe holds a valid beat.

Behaviour:
- Reset:
  - srst is sampled at the rising edge; at that edge all outputs are forced to 0.
  - FSM goes to IDLE, all latency pipe stages are invalidated, and the round-robin pointer is set so requester 0 has top priority.
  - Memory array contents are NOT cleared.
- Write port:
  - When wr_en is high at an edge, mem[wr_addr] is written.
  - Writes are independent of the read FSM and are never stalled.
- FSM states:
  - IDLE:
    - If any rd_req bit is set, the winner is chosen round-robin: search starts at last_granted+1 and wraps modulo N_RD.
    - rd_gnt[winner] is driven combinationally high in this same cycle (cycle T).
    - The winner's addr, len and id are captured; next state is BURST.
    - With no request, the FSM stays in IDLE.
  - BURST:
    - One beat is issued per cycle, T+1 .. T+len+1.
    - The address increments by 1 each beat and wraps from DEPTH-1 to 0.
    - A down-counter tracks the remaining beats; the beat issued when the counter is 0 carries last=1, and the next state is IDLE.
    - rd_gnt is 0 throughout BURST.
    - Consecutive bursts therefore have exactly one idle issue cycle between them (the next IDLE grant cycle).
  - last_granted updates only on a grant.
- Requester rules:
  - A requester that drops rd_req before it is granted is simply not served.
  - rd_addr and rd_len are sampled only in the grant cycle.
- Read pipe:
  - Memory is read at issue; the beat then traverses an RD_LAT-stage register pipe carrying valid, id, last and data.
  - A beat issued at cycle t appears on the outputs with rd_valid=1 in cycle t+RD_LAT.
  - Outputs are registered, and rd_data, rd_id and rd_last are 0 whenever rd_valid=0.
- Read/write collision: a read issued in the same cycle as a write to the same address returns the OLD data; a read issued one cycle later returns the new data.
- srst mid-burst:
  - The burst is abandoned and in-flight beats are discarded.
  - rd_valid stays 0 until a new grant's beats emerge.
- busy deasserts in the cycle after the final beat leaves the pipe.

Test Plan:
1. Reset: hold srst 2 cycles with rd_req=2'b11 -> rd_gnt, rd_valid, rd_data, rd_id, rd_last and busy are all 0; no grant is issued while srst=1.
2. Single burst (RD_LAT=3):
   - Stimulus: write mem[5..8]=32'hA0..A3, then requester 0 asserts addr=5, len=3 at cycle T.
   - Required: rd_gnt=2'b01 at T; rd_valid at T+4..T+7 with data A0,A1,A2,A3; rd_id=0; rd_last only at T+7.
3. Round-robin: after reset, rd_req=2'b11 held continuously with len=0 for both -> grant order is 0, 1, 0, 1, with grants 2 cycles apart.
4. Wrap: requester 1, addr=DEPTH-2, len=3 -> beats return mem[4094], mem[4095], mem[0], mem[1] with rd_id=1.
5. Collision:
   - Stimulus: mem[9]=32'h11; at cycle t write 32'h22 to addr 9 while a burst issues a beat at addr 9.
   - Required: the returned data is 32'h11; a later read of addr 9 returns 32'h22.
6. Mid-burst reset: srst pulsed 1 cycle during the 3rd beat of a len=7 burst -> rd_valid is 0 from the next edge and stays 0; busy=0; a new request is then granted normally.

Source files
------------

// File: rtl/dram_burst_model.sv
// Multi-requester DRAM behavioural model: always-accepted write port,
// round-robin read arbitration, wrapping burst reads and a fixed-latency
// registered read pipe carrying valid/id/last/data.
module dram_burst_model #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int N_RD        = 2,
    parameter int ID_WIDTH    = 1,
    parameter int BURST_WIDTH = 4,
    parameter int RD_LAT      = 3
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [N_RD-1:0]             rd_req,
    input  logic [N_RD*ADDR_WIDTH-1:0]  rd_addr,
    input  logic [N_RD*BURST_WIDTH-1:0] rd_len,
    output logic [N_RD-1:0]             rd_gnt,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [ID_WIDTH-1:0]         rd_id,
    output logic                        rd_last,
    output logic                        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BURST_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ID_WIDTH-1:0]     last_gnt_q, last_gnt_d;

    logic [RD_LAT-1:0]                 pipe_valid_q, pipe_valid_d;
    logic [RD_LAT-1:0]                 pipe_last_q, pipe_last_d;
    logic [RD_LAT-1:0][ID_WIDTH-1:0]   pipe_id_q, pipe_id_d;
    logic [RD_LAT-1:0][DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                   any_req;
    logic                   found_hi, found_lo;
    logic [ID_WIDTH-1:0]    win_hi, win_lo, winner;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [BURST_WIDTH-1:0] sel_len;
    logic [N_RD-1:0]        gnt;
    logic                   issue_valid;
    logic                   issue_last;
    logic [DATA_WIDTH-1:0]  issue_data;

    // Storage writes are never stalled and never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Round-robin pick: first requester above the last grant, else wrap to the lowest one.
    always_comb begin
        any_req  = |rd_req;
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < N_RD; i++) begin
            if (rd_req[i] && !found_hi && (i > int'(last_gnt_q))) begin
                found_hi = 1'b1;
                win_hi   = ID_WIDTH'(i);
            end
            if (rd_req[i] && !found_lo && (i <= int'(last_gnt_q))) begin
                found_lo = 1'b1;
                win_lo   = ID_WIDTH'(i);
            end
        end
        winner = found_hi ? win_hi : win_lo;
        for (int i = 0; i < N_RD; i++) begin
            if (ID_WIDTH'(i) == winner) begin
                sel_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = rd_len[i*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    // Grant in IDLE, then issue one beat per cycle until the down-counter hits zero.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        last_gnt_d  = last_gnt_q;
        gnt         = '0;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req && !srst) begin
                    gnt        = {{(N_RD-1){1'b0}}, 1'b1} << winner;
                    state_d    = BURST;
                    addr_d     = sel_addr;
                    cnt_d      = sel_len;
                    id_d       = winner;
                    last_gnt_d = winner;
                end
            end
            BURST: begin
                issue_valid = 1'b1;
                issue_last  = (cnt_q == '0);
                addr_d      = addr_q + ADDR_WIDTH'(1);
                cnt_d       = cnt_q - BURST_WIDTH'(1);
                if (issue_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory is read at issue, so a same-cycle write to that address is not yet visible.
    always_comb begin
        issue_data     = mem[addr_q];
        pipe_valid_d   = pipe_valid_q;
        pipe_last_d    = pipe_last_q;
        pipe_id_d      = pipe_id_q;
        pipe_data_d    = pipe_data_q;
        pipe_valid_d[0] = issue_valid;
        pipe_last_d[0]  = issue_valid & issue_last;
        pipe_id_d[0]    = issue_valid ? id_q : '0;
        pipe_data_d[0]  = issue_valid ? issue_data : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_last_d[i]  = pipe_last_q[i-1];
            pipe_id_d[i]    = pipe_id_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end
    end

    // State, arbitration pointer and latency pipe registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
            last_gnt_q   <= ID_WIDTH'(N_RD - 1);
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
            pipe_id_q    <= '0;
            pipe_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_gnt_q   <= last_gnt_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_last_q  <= pipe_last_d;
            pipe_id_q    <= pipe_id_d;
            pipe_data_q  <= pipe_data_d;
        end
    end

    assign rd_gnt   = gnt;
    assign rd_valid = pipe_valid_q[RD_LAT-1];
    assign rd_last  = pipe_last_q[RD_LAT-1];
    assign rd_id    = pipe_id_q[RD_LAT-1];
    assign rd_data  = pipe_data_q[RD_LAT-1];
    assign busy     = (state_q == BURST) | (|pipe_valid_q);

endmodule

// File: tb/tb_dram_burst_model.sv
// Directed bench for dram_burst_model: a scoreboard queue of expected beats
// is filled at every grant and drained by a monitor as rd_valid beats appear.
module tb_dram_burst_model;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int NR    = 2;
    localparam int IW    = 1;
    localparam int BW    = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             srst;
    logic             wrEn;
    logic [AW-1:0]    wrAddr;
    logic [DW-1:0]    wrData;
    logic [NR-1:0]    rdReq;
    logic [NR*AW-1:0] rdAddr;
    logic [NR*BW-1:0] rdLen;
    logic [NR-1:0]    rdGnt;
    logic             rdValid;
    logic [DW-1:0]    rdData;
    logic [IW-1:0]    rdId;
    logic             rdLast;
    logic             busy;

    typedef struct {
        logic [DW-1:0] data;
        int            id;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t         sbq[$];
    beat_t         monBeat;
    logic [DW-1:0] model [DEPTH];
    int            cyc = 0;
    int            assertCount = 0;
    int            failCount = 0;
    logic          monitorOn = 1'b0;

    dram_burst_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_RD(NR),
        .ID_WIDTH(IW), .BURST_WIDTH(BW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .srst(srst),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_req(rdReq), .rd_addr(rdAddr), .rd_len(rdLen),
        .rd_gnt(rdGnt), .rd_valid(rdValid), .rd_data(rdData),
        .rd_id(rdId), .rd_last(rdLast), .busy(busy)
    );

    // Free-running clock with a cycle index used to time expected beats.
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected beats of one burst granted in cycle t.
    task automatic pushBurst(input int r, input int addr, input int len, input int t);
        beat_t b;
        for (int k = 0; k <= len; k++) begin
            b.data = model[(addr + k) % DEPTH];
            b.id   = r;
            b.last = (k == len);
            b.cyc  = t + LAT + 1 + k;
            sbq.push_back(b);
        end
    endtask

    // Single write, tracked in the bench's own memory image.
    task automatic writeWord(input int addr, input logic [DW-1:0] data);
        wrEn   = 1'b1;
        wrAddr = AW'(addr);
        wrData = data;
        model[addr] = data;
        @(posedge clk); #1;
        wrEn = 1'b0;
    endtask

    // Raise a request, wait (bounded) for its grant, record expected beats, then drop it.
    task automatic applyStimulus(input int r, input int addr, input int len);
        bit granted;
        granted = 1'b0;
        rdAddr[r*AW +: AW] = AW'(addr);
        rdLen[r*BW +: BW]  = BW'(len);
        rdReq[r] = 1'b1;
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            if (rdGnt !== '0) begin
                granted = 1'b1;
                checkOutput($sformatf("grant r%0d", r), rdGnt, 64'(1 << r));
                pushBurst(r, addr, len, cyc);
            end
            @(posedge clk); #1;
        end
        if (!granted) checkOutput($sformatf("grant timeout r%0d", r), rdGnt, 64'(1 << r));
        rdReq[r] = 1'b0;
    endtask

    // Wait (bounded) for all expected beats, then busy must have dropped.
    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sbq.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput({tag, " queue empty"}, sbq.size(), 0);
        checkOutput({tag, " busy low"}, busy, 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every beat must match the head entry and its exact cycle.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (rdValid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected beat", rdValid, 0);
                end else begin
                    monBeat = sbq.pop_front();
                    checkOutput("beat cycle", cyc, monBeat.cyc);
                    checkOutput("beat data", rdData, monBeat.data);
                    checkOutput("beat id", rdId, monBeat.id);
                    checkOutput("beat last", rdLast, monBeat.last);
                end
            end else begin
                checkOutput("idle outputs zero", {rdValid, rdData, rdId, rdLast}, 0);
                if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    checkOutput("missing beat", rdValid, 1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // Hard stop in case something wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        logic [NR-1:0] expGnt;
        srst   = 1'b1;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        rdReq  = 2'b11;
        rdAddr = '0;
        rdLen  = '0;

        // Reset held two cycles with both requests up: no grants, outputs cleared.
        @(negedge clk);
        checkOutput("reset c1 gnt", rdGnt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset c2 gnt", rdGnt, 0);
        checkOutput("reset outputs", {rdValid, rdData, rdId, rdLast}, 0);
        checkOutput("reset busy", busy, 0);
        monitorOn = 1'b1;
        @(posedge clk); #1;
        srst  = 1'b0;
        rdReq = '0;

        // Single 4-beat burst from requester 0.
        writeWord(5, 32'hA0);
        writeWord(6, 32'hA1);
        writeWord(7, 32'hA2);
        writeWord(8, 32'hA3);
        applyStimulus(0, 5, 3);
        drain("single");

        // Burst wrapping from the top of memory back to 0.
        writeWord(DEPTH - 2, 32'hB0);
        writeWord(DEPTH - 1, 32'hB1);
        writeWord(0, 32'hB2);
        writeWord(1, 32'hB3);
        applyStimulus(1, DEPTH - 2, 3);
        drain("wrap");

        // Read issued alongside a write to the same address sees old data.
        writeWord(9, 32'h11);
        applyStimulus(0, 9, 0);
        writeWord(9, 32'h22);
        drain("collision old");
        applyStimulus(0, 9, 0);
        drain("collision new");

        // Round-robin after reset with both requesters held.
        writeWord(30, 32'hC0);
        writeWord(31, 32'hC1);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        rdAddr = {AW'(31), AW'(30)};
        rdLen  = '0;
        rdReq  = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expGnt = (k % 2 != 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput($sformatf("rr grant %0d", k), rdGnt, expGnt);
            if (expGnt == 2'b01) pushBurst(0, 30, 0, cyc);
            if (expGnt == 2'b10) pushBurst(1, 31, 0, cyc);
            @(posedge clk); #1;
        end
        rdReq = '0;
        drain("rr");

        // Reset during the third beat of an 8-beat burst.
        for (int a = 16; a < 24; a++) writeWord(a, DW'(32'hD0 + a));
        applyStimulus(0, 16, 7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        sbq.delete();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("post reset valid %0d", k), rdValid, 0);
            checkOutput($sformatf("post reset busy %0d", k), busy, 0);
            @(posedge clk); #1;
        end
        applyStimulus(1, 20, 1);
        drain("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
